// File: rtl/clock_set_ctrl.sv
// Key-driven mode controller for the digital clock: time/alarm setting FSM,
// timekeeper load strobe, alarm registers and flag, display mux and field blinking.
module clock_set_ctrl #(
  parameter int          BLINK_DIV = 25_000_000,
  parameter int          TIMEOUT   = 500_000_000,
  parameter logic [7:0]  AL_HR_RST = 8'h07,
  parameter logic [7:0]  AL_MN_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_cancel,
  input  logic [7:0] hr,
  input  logic [7:0] mn,
  input  logic [7:0] sd,
  output logic       set_en,
  output logic [7:0] set_hr,
  output logic [7:0] set_mn,
  output logic [7:0] set_sd,
  output logic [7:0] disp_hr,
  output logic [7:0] disp_mn,
  output logic       blank_hr,
  output logic       blank_mn,
  output logic [2:0] mode,
  output logic       al_en,
  output logic       alarm
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HR = 3'd1,
    SET_MN = 3'd2,
    AL_HR  = 3'd3,
    AL_MN  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_sh_hr, r_sh_mn, r_al_hr, r_al_mn;
  logic            r_al_en, r_alarm, r_al_done;
  logic            r_set_en;
  logic [7:0]      r_set_hr, r_set_mn;
  logic [TW-1:0]   r_tmo_cnt;
  logic [BW-1:0]   r_blink_div;
  logic            r_phase;
  logic            w_any_key, w_act, w_cancel, w_mode, w_inc, w_tmo, w_state_chg, w_al_hit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  // While the alarm is ringing, any key only silences it.
  always_comb begin
    w_any_key = key_cancel | key_mode | key_inc;
    w_act     = w_any_key & ~r_alarm;
    w_cancel  = w_act & key_cancel;
    w_mode    = w_act & ~key_cancel & key_mode;
    w_inc     = w_act & ~key_cancel & ~key_mode & key_inc;
    w_tmo     = (r_state != RUN) && !w_any_key && (r_tmo_cnt == TMO_LAST);
    w_al_hit  = (r_state == RUN) && r_al_en && (hr == r_al_hr) && (mn == r_al_mn) && (sd == 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state != RUN && (w_cancel || w_tmo)) begin
      w_state_nxt = RUN;
    end else if (w_mode) begin
      case (r_state)
        RUN:     w_state_nxt = SET_HR;
        SET_HR:  w_state_nxt = SET_MN;
        SET_MN:  w_state_nxt = AL_HR;
        AL_HR:   w_state_nxt = AL_MN;
        default: w_state_nxt = RUN;
      endcase
    end
    w_state_chg = (w_state_nxt != r_state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_hr  <= 8'h00;
      r_sh_mn  <= 8'h00;
      r_al_hr  <= AL_HR_RST;
      r_al_mn  <= AL_MN_RST;
      r_al_en  <= 1'b0;
      r_set_en <= 1'b0;
      r_set_hr <= 8'h00;
      r_set_mn <= 8'h00;
    end else begin
      r_set_en <= 1'b0;
      if (r_state == RUN && w_mode) begin
        r_sh_hr <= hr;
        r_sh_mn <= mn;
      end
      if (r_state == SET_MN && w_mode) begin
        r_set_en <= 1'b1;
        r_set_hr <= r_sh_hr;
        r_set_mn <= r_sh_mn;
      end
      if (w_inc) begin
        case (r_state)
          RUN:     r_al_en <= ~r_al_en;
          SET_HR:  r_sh_hr <= bcd_inc(r_sh_hr, 8'h23);
          SET_MN:  r_sh_mn <= bcd_inc(r_sh_mn, 8'h59);
          AL_HR:   r_al_hr <= bcd_inc(r_al_hr, 8'h23);
          default: r_al_mn <= bcd_inc(r_al_mn, 8'h59);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_tmo_cnt <= '0;
    else if (w_state_chg || w_any_key || r_state == RUN) r_tmo_cnt <= '0;
    else                                                r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Restarting the blink on every increment keeps the edited field visible after a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_div <= '0;
      r_phase     <= 1'b0;
    end else if (w_state_chg || w_inc || r_state == RUN) begin
      r_blink_div <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_div == BLINK_LAST) begin
      r_blink_div <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_div <= r_blink_div + 1'b1;
    end
  end

  // r_al_done blocks a re-trigger until the minute moves away from the alarm minute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm   <= 1'b0;
      r_al_done <= 1'b0;
    end else begin
      if (mn != r_al_mn)    r_al_done <= 1'b0;
      else if (r_alarm)     r_al_done <= 1'b1;
      if (w_any_key || r_state != RUN || w_state_chg || mn != r_al_mn) r_alarm <= 1'b0;
      else if (w_al_hit && !r_al_done)                                 r_alarm <= 1'b1;
    end
  end

  always_comb begin
    disp_hr = hr;
    disp_mn = mn;
    case (r_state)
      SET_HR, SET_MN: begin disp_hr = r_sh_hr; disp_mn = r_sh_mn; end
      AL_HR, AL_MN:   begin disp_hr = r_al_hr; disp_mn = r_al_mn; end
      default:        ;
    endcase
  end

  assign blank_hr = r_phase & ((r_state == SET_HR) | (r_state == AL_HR));
  assign blank_mn = r_phase & ((r_state == SET_MN) | (r_state == AL_MN));
  assign mode     = r_state;
  assign set_en   = r_set_en;
  assign set_hr   = r_set_hr;
  assign set_mn   = r_set_mn;
  assign set_sd   = 8'h00;
  assign al_en    = r_al_en;
  assign alarm    = r_alarm;

endmodule
